// File: rtl/pinball_turn_ctrl_pkg.sv
// rtl/pinball_turn_ctrl_pkg.sv - shared state encoding, zone points and winner codes
package pinball_turn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_PLAY   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SWAP   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [2:0] PTS_DRAIN   = 3'd0;
    localparam logic [2:0] PTS_ONE     = 3'd1;
    localparam logic [2:0] PTS_TWO     = 3'd2;
    localparam logic [2:0] PTS_JACKPOT = 3'd5;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/pinball_zone_decode.sv
// rtl/pinball_zone_decode.sv - sensor to hit/points/jackpot decode, drain > +1 > +2 > jackpot
module pinball_zone_decode
    import pinball_turn_ctrl_pkg::*;
(
    input  logic [6:0] sensor_i,
    output logic       hit_o,
    output logic [2:0] points_o,
    output logic       jackpot_o
);

    always_comb begin
        hit_o     = |sensor_i;
        points_o  = PTS_DRAIN;
        jackpot_o = 1'b0;
        if (sensor_i[0] || sensor_i[6]) begin
            points_o = PTS_DRAIN;
        end else if (sensor_i[1] || sensor_i[5]) begin
            points_o = PTS_ONE;
        end else if (sensor_i[2] || sensor_i[4]) begin
            points_o = PTS_TWO;
        end else if (sensor_i[3]) begin
            points_o  = PTS_JACKPOT;
            jackpot_o = 1'b1;
        end
    end

endmodule

// File: rtl/pinball_turn_ctrl.sv
// rtl/pinball_turn_ctrl.sv - two-player pinball turn sequencer with scores and ball counts
module pinball_turn_ctrl
    import pinball_turn_ctrl_pkg::*;
#(
    parameter int BALLS     = 3,
    parameter int WIN_SCORE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] sensor,
    output logic       active_player,
    output logic [2:0] score_p0,
    output logic [2:0] score_p1,
    output logic [1:0] balls_left,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [1:0] BALLS_Q = 2'(BALLS);
    localparam logic [2:0] WIN_Q   = 3'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [2:0] p0_q, p0_d;
    logic [2:0] p1_q, p1_d;
    logic       ap_q, ap_d;
    logic [1:0] balls_q, balls_d;
    logic       turn_end_q, turn_end_d;

    logic       hit;
    logic [2:0] points;
    logic       jackpot;
    logic [2:0] cur_score;
    logic [2:0] new_score;
    logic [1:0] new_balls;

    pinball_zone_decode u_decode (
        .sensor_i  (sensor),
        .hit_o     (hit),
        .points_o  (points),
        .jackpot_o (jackpot)
    );

    // Scores never exceed 5: a turn ends at WIN_SCORE, so a 3-bit sum suffices.
    assign cur_score = ap_q ? p1_q : p0_q;
    assign new_score = jackpot ? PTS_JACKPOT : cur_score + points;
    assign new_balls = balls_q - 2'd1;

    always_comb begin
        state_d    = state_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        ap_d       = ap_q;
        balls_d    = balls_q;
        turn_end_d = turn_end_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d    = ST_ARM;
                    p0_d       = 3'd0;
                    p1_d       = 3'd0;
                    ap_d       = 1'b0;
                    balls_d    = BALLS_Q;
                    turn_end_d = 1'b0;
                end
            end
            ST_ARM: begin
                if (sensor == 7'd0) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (hit) begin
                    state_d = ST_SETTLE;
                    if (ap_q) p1_d = new_score;
                    else      p0_d = new_score;
                    balls_d    = new_balls;
                    turn_end_d = (new_score >= WIN_Q) || (new_balls == 2'd0);
                end
            end
            ST_SETTLE: begin
                if (sensor == 7'd0) begin
                    if (!turn_end_q) state_d = ST_PLAY;
                    else if (ap_q)   state_d = ST_OVER;
                    else             state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_d    = ST_PLAY;
                ap_d       = 1'b1;
                balls_d    = BALLS_Q;
                turn_end_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            p0_q       <= 3'd0;
            p1_q       <= 3'd0;
            ap_q       <= 1'b0;
            balls_q    <= 2'd0;
            turn_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            ap_q       <= ap_d;
            balls_q    <= balls_d;
            turn_end_q <= turn_end_d;
        end
    end

    always_comb begin
        winner = WIN_NONE;
        if (state_q == ST_OVER) begin
            if (p0_q > p1_q)      winner = WIN_P0;
            else if (p1_q > p0_q) winner = WIN_P1;
            else                  winner = WIN_TIE;
        end
    end

    assign active_player = ap_q;
    assign score_p0      = p0_q;
    assign score_p1      = p1_q;
    assign balls_left    = balls_q;
    assign game_over     = (state_q == ST_OVER);

endmodule

// File: tb/tb_pinball_turn_ctrl.sv
// tb/tb_pinball_turn_ctrl.sv - vector-table bench for pinball_turn_ctrl
module tb_pinball_turn_ctrl;
    import pinball_turn_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] sensor;
    logic       active_player;
    logic [2:0] score_p0;
    logic [2:0] score_p1;
    logic [1:0] balls_left;
    logic       game_over;
    logic [1:0] winner;

    pinball_turn_ctrl #(.BALLS(3), .WIN_SCORE(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .sensor        (sensor),
        .active_player (active_player),
        .score_p0      (score_p0),
        .score_p1      (score_p1),
        .balls_left    (balls_left),
        .game_over     (game_over),
        .winner        (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic [6:0] sensor;
        logic [2:0] st;
        logic [2:0] p0;
        logic [2:0] p1;
        logic       ap;
        logic [1:0] balls;
        logic       go;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;
    logic done;

    task automatic add(input logic r, input logic s, input logic [6:0] sn, input state_t st,
                       input logic [2:0] p0, input logic [2:0] p1, input logic ap,
                       input logic [1:0] b, input logic go, input logic [1:0] w);
        vec_t v;
        v.rst_n = r; v.start = s; v.sensor = sn; v.st = st;
        v.p0 = p0; v.p1 = p1; v.ap = ap; v.balls = b; v.go = go; v.win = w;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL timeout: vector sequence did not complete, total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        done  = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        sensor = 7'd0;

        // reset, start, single +1 hit, drain-vs-jackpot priority, p0 jackpot ends turn
        add(0, 0, 7'b0000000, ST_IDLE,   0, 0, 0, 0, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_IDLE,   0, 0, 0, 0, 0, 2'b00);
        add(1, 1, 7'b0000000, ST_ARM,    0, 0, 0, 3, 0, 2'b00);
        add(1, 1, 7'b0000000, ST_PLAY,   0, 0, 0, 3, 0, 2'b00);
        add(1, 0, 7'b0000010, ST_SETTLE, 1, 0, 0, 2, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   1, 0, 0, 2, 0, 2'b00);
        add(1, 0, 7'b0001001, ST_SETTLE, 1, 0, 0, 1, 0, 2'b00);
        add(1, 0, 7'b0001001, ST_SETTLE, 1, 0, 0, 1, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   1, 0, 0, 1, 0, 2'b00);
        add(1, 0, 7'b0001000, ST_SETTLE, 5, 0, 0, 0, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_SWAP,   5, 0, 0, 0, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   5, 0, 1, 3, 0, 2'b00);
        // p1 +2 then sensor held: only one +2 counted
        add(1, 0, 7'b0000100, ST_SETTLE, 5, 2, 1, 2, 0, 2'b00);
        for (int i = 0; i < 10; i++)
            add(1, 0, 7'b0000100, ST_SETTLE, 5, 2, 1, 2, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   5, 2, 1, 2, 0, 2'b00);
        add(1, 0, 7'b0100000, ST_SETTLE, 5, 3, 1, 1, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   5, 3, 1, 1, 0, 2'b00);
        add(1, 0, 7'b1000000, ST_SETTLE, 5, 3, 1, 0, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_OVER,   5, 3, 1, 0, 1, 2'b01);
        add(1, 0, 7'b0000000, ST_OVER,   5, 3, 1, 0, 1, 2'b01);
        add(1, 1, 7'b0000000, ST_ARM,    0, 0, 0, 3, 0, 2'b00);
        // full game: p0 ends at 2 after 3 balls, p1 reaches 4 after 2 balls
        add(1, 0, 7'b0000000, ST_PLAY,   0, 0, 0, 3, 0, 2'b00);
        add(1, 0, 7'b0000100, ST_SETTLE, 2, 0, 0, 2, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   2, 0, 0, 2, 0, 2'b00);
        add(1, 0, 7'b0000001, ST_SETTLE, 2, 0, 0, 1, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   2, 0, 0, 1, 0, 2'b00);
        add(1, 0, 7'b1000000, ST_SETTLE, 2, 0, 0, 0, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_SWAP,   2, 0, 0, 0, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   2, 0, 1, 3, 0, 2'b00);
        add(1, 0, 7'b0010000, ST_SETTLE, 2, 2, 1, 2, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   2, 2, 1, 2, 0, 2'b00);
        add(1, 0, 7'b0010000, ST_SETTLE, 2, 4, 1, 1, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_OVER,   2, 4, 1, 1, 1, 2'b10);
        add(1, 1, 7'b0000000, ST_ARM,    0, 0, 0, 3, 0, 2'b00);
        // reset during p1 SETTLE, start and sensors ignored while in reset
        add(1, 0, 7'b0000000, ST_PLAY,   0, 0, 0, 3, 0, 2'b00);
        add(1, 0, 7'b0001000, ST_SETTLE, 5, 0, 0, 2, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_SWAP,   5, 0, 0, 2, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   5, 0, 1, 3, 0, 2'b00);
        add(1, 0, 7'b0000010, ST_SETTLE, 5, 1, 1, 2, 0, 2'b00);
        add(0, 1, 7'b0000010, ST_IDLE,   0, 0, 0, 0, 0, 2'b00);
        add(1, 1, 7'b0000000, ST_ARM,    0, 0, 0, 3, 0, 2'b00);
        add(1, 0, 7'b0000010, ST_ARM,    0, 0, 0, 3, 0, 2'b00);
        add(1, 1, 7'b0000000, ST_PLAY,   0, 0, 0, 3, 0, 2'b00);
        // all-drain game ends in a tie; start ignored in PLAY/SETTLE/SWAP
        add(1, 1, 7'b0000001, ST_SETTLE, 0, 0, 0, 2, 0, 2'b00);
        add(1, 1, 7'b0000000, ST_PLAY,   0, 0, 0, 2, 0, 2'b00);
        add(1, 0, 7'b0000001, ST_SETTLE, 0, 0, 0, 1, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   0, 0, 0, 1, 0, 2'b00);
        add(1, 0, 7'b0000001, ST_SETTLE, 0, 0, 0, 0, 0, 2'b00);
        add(1, 1, 7'b0000000, ST_SWAP,   0, 0, 0, 0, 0, 2'b00);
        add(1, 1, 7'b0000000, ST_PLAY,   0, 0, 1, 3, 0, 2'b00);
        add(1, 0, 7'b1000000, ST_SETTLE, 0, 0, 1, 2, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   0, 0, 1, 2, 0, 2'b00);
        add(1, 0, 7'b1000000, ST_SETTLE, 0, 0, 1, 1, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_PLAY,   0, 0, 1, 1, 0, 2'b00);
        add(1, 0, 7'b1000000, ST_SETTLE, 0, 0, 1, 0, 0, 2'b00);
        add(1, 0, 7'b0000000, ST_OVER,   0, 0, 1, 0, 1, 2'b11);

        @(negedge clk);
        rst_n  = 1'b0;
        start  = 1'b1;
        sensor = 7'b0001000;
        @(posedge clk);
        #1;
        total++;
        if (dut.state_q !== ST_IDLE || score_p0 !== 3'd0 || score_p1 !== 3'd0 ||
            active_player !== 1'b0 || balls_left !== 2'd0 || dut.turn_end_q !== 1'b0 ||
            game_over !== 1'b0 || winner !== 2'b00) begin
            bad++;
            $display("FAIL reset: st=%0d p0=%0d p1=%0d ap=%0d balls=%0d te=%0d go=%0d win=%b",
                     3'(dut.state_q), score_p0, score_p1, active_player, balls_left,
                     dut.turn_end_q, game_over, winner);
        end

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n  = vecs[i].rst_n;
            start  = vecs[i].start;
            sensor = vecs[i].sensor;
            @(posedge clk);
            #1;
            total++;
            if (3'(dut.state_q) !== vecs[i].st || score_p0 !== vecs[i].p0 ||
                score_p1 !== vecs[i].p1 || active_player !== vecs[i].ap ||
                balls_left !== vecs[i].balls || game_over !== vecs[i].go ||
                winner !== vecs[i].win) begin
                bad++;
                $display("FAIL vec%0d: got st=%0d p0=%0d p1=%0d ap=%0d balls=%0d go=%0d win=%b want st=%0d p0=%0d p1=%0d ap=%0d balls=%0d go=%0d win=%b",
                         i, 3'(dut.state_q), score_p0, score_p1, active_player, balls_left,
                         game_over, winner, vecs[i].st, vecs[i].p0, vecs[i].p1, vecs[i].ap,
                         vecs[i].balls, vecs[i].go, vecs[i].win);
            end
            @(negedge clk);
        end

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
